mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter LAT, default 1, giving memory read latency in cycles; legal range 1..4.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
  clk  in  1  sole clock; all state updates on rising edge.
  reset  in  1  asynchronous, active-low reset.
  cpu_req  in  1  CPU (port 0) access request; held until cpu_done.
  cpu_we  in  1  CPU write enable.
  cpu_addr  in  32  CPU byte address.
  cpu_wdata  in  32  CPU write data.
  cpu_done  out  1  one-cycle completion pulse to CPU.
  dma_req  in  1  DMA (port 1) access request; held until dma_done.
  dma_we  in  1  DMA write enable.
  dma_addr  in  32  DMA byte address.
  dma_wdata  in  32  DMA write data.
  dma_done  out  1  one-cycle completion pulse to DMA.
  rdata  out  32  registered read data, valid while either done is high.
  err  out  1  misaligned-access flag, valid while either done is high.
  mem_en  out  1  memory access strobe.
  mem_we  out  1  memory write enable.
  mem_addr  out  32  latched word address to memory.
  mem_wdata  out  32  latched write data to memory.
  mem_rdata  in  32  memory read data, valid LAT edges after mem_en edge.

Function
REQ-003 The block SHALL use four states: IDLE, ACCESS, WAIT, RESP.
REQ-004 In IDLE, at a rising edge with any request high, the block SHALL latch the winner's we/addr/wdata, record the winner in a grant register, and enter ACCESS.
REQ-005 Arbitration SHALL be round-robin: single requester wins; if both request, the port not recorded in last_gnt wins; last_gnt updates to the winner on every grant.
REQ-006 The block SHALL drive mem_en=1 and mem_we=latched we for exactly the one ACCESS cycle, and 0 in all other states.
REQ-007 mem_addr and mem_wdata SHALL hold latched values from grant until the next grant.
REQ-008 From ACCESS the block SHALL enter RESP if LAT=1, else WAIT; WAIT SHALL last LAT-1 cycles via a down-counter, then enter RESP.
REQ-009 On the edge leaving ACCESS (LAT=1) or WAIT (LAT>1), a read SHALL capture mem_rdata into rdata; a write SHALL leave rdata unchanged.
REQ-010 In RESP the granted port's done SHALL be high for exactly one cycle; the other done SHALL stay 0; the next state SHALL be IDLE.
REQ-011 Request-to-done latency SHALL be LAT+1 cycles after the grant edge; a new grant is possible at the edge leaving IDLE, so back-to-back throughput is one access per LAT+2 cycles.
REQ-012 If latched addr[1:0]!=0, the block SHALL skip memory (mem_en stays 0 in ACCESS), go ACCESS->RESP directly, assert err with done, and leave rdata unchanged.
REQ-013 A requester deasserting req mid-transaction SHALL NOT abort it; the access SHALL complete with latched values and done SHALL still pulse.
REQ-014 A requester still holding req in the RESP cycle SHALL be treated as a new request at the following IDLE edge.
REQ-015 Changes to the granted port's we/addr/wdata after grant SHALL have no effect on the transaction in flight.

Reset
REQ-016 While reset=0, the block SHALL force state=IDLE, last_gnt=DMA (CPU wins the first tie), wait counter=0, and mem_en, mem_we, cpu_done, dma_done, err=0, with mem_addr, mem_wdata, rdata=0.
REQ-017 Reset assertion mid-transaction SHALL abort it immediately with no done pulse; operation SHALL resume from IDLE on the first edge after reset returns to 1.

Verification
REQ-018 CPU read, LAT=1: cpu_req=1, cpu_addr=0x100, mem_rdata=0xDEADBEEF -> mem_en for 1 cycle with mem_addr=0x100; cpu_done one cycle later with rdata=0xDEADBEEF, err=0.
REQ-019 Simultaneous requests after reset: cpu_req=dma_req=1 held -> CPU granted first, DMA second; exactly one done per transaction; grants alternate CPU/DMA.
REQ-020 DMA write, LAT=3: dma_we=1, dma_addr=0x40, dma_wdata=0x12345678 -> mem_we=1 for 1 cycle; dma_done 4 cycles after grant; rdata unchanged.
REQ-021 Misaligned: cpu_addr=0x102 -> mem_en never asserted; cpu_done and err high together the cycle after ACCESS.
REQ-022 Reset mid-op: reset=0 during WAIT (LAT=4) -> all outputs 0 immediately; no done pulse; the next request after release is granted normally.
REQ-023 Early drop: cpu_req deasserted the cycle after grant and cpu_addr changed -> access completes to the original address; cpu_done pulses once.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU/DMA) round-robin arbiter in front of a fixed-latency memory
module mem_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_done,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  // WAIT spans LAT-1 cycles: counter loads LAT-2 and leaves WAIT when it reaches zero
  localparam logic [1:0] WAIT_INIT = (LAT > 1) ? 2'(LAT - 2) : 2'd0;
  state_t state, state_nxt;
  logic gnt;
  logic we;
  logic [1:0] cnt;
  logic dma_win;
  logic grant;
  logic misaligned;
  logic capture;
  // gnt doubles as last_gnt: 1 means DMA was granted last, so CPU wins the next tie
  assign dma_win    = dma_req & (~cpu_req | ~gnt);
  assign grant      = (state == IDLE) & (cpu_req | dma_req);
  assign misaligned = |mem_addr[1:0];
  assign capture    = ~we & ~misaligned & (((state == ACCESS) & (LAT == 1)) | ((state == WAIT) & (cnt == 2'd0)));
  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end
  // Next state and the per-state output strobes
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_done  = 1'b0;
    dma_done  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE:    state_nxt = (cpu_req | dma_req) ? ACCESS : IDLE;
      ACCESS: begin
        state_nxt = (misaligned || LAT == 1) ? RESP : WAIT;
        mem_en    = ~misaligned;
        mem_we    = ~misaligned & we;
      end
      WAIT:    state_nxt = (cnt == 2'd0) ? RESP : WAIT;
      RESP: begin
        state_nxt = IDLE;
        cpu_done  = ~gnt;
        dma_done  = gnt;
        err       = misaligned;
      end
      default: state_nxt = IDLE;
    endcase
  end
  // Grant latch, wait counter and read-data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= 1'b1;
      we        <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      rdata     <= 32'd0;
      cnt       <= 2'd0;
    end else begin
      if (grant) begin
        gnt       <= dma_win;
        we        <= dma_win ? dma_we : cpu_we;
        mem_addr  <= dma_win ? dma_addr : cpu_addr;
        mem_wdata <= dma_win ? dma_wdata : cpu_wdata;
      end
      if (state == ACCESS) cnt <= WAIT_INIT;
      else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (capture) rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: three arbiters (LAT 1/3/4) driven from a vector table with a scoreboard queue
module tb_mem_arbiter;
  typedef struct {
    int          k;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          scramble;
    bit          exp_err;
  } vec_t;
  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          lat;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic        cpu_req   [3];
  logic        cpu_we    [3];
  logic [31:0] cpu_addr  [3];
  logic [31:0] cpu_wdata [3];
  logic        cpu_done  [3];
  logic        dma_req   [3];
  logic        dma_we    [3];
  logic [31:0] dma_addr  [3];
  logic [31:0] dma_wdata [3];
  logic        dma_done  [3];
  logic [31:0] rdata     [3];
  logic        err       [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [31:0] mem_addr  [3];
  logic [31:0] mem_wdata [3];
  logic [31:0] mem_rdata [3];
  logic [31:0] rd_model  [3];
  exp_t sb[$];
  vec_t vecs[$];
  int checks = 0;
  int errors = 0;
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 4;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    mem_arbiter #(.LAT(L)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]), .cpu_done(cpu_done[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]), .dma_wdata(dma_wdata[g]), .dma_done(dma_done[g]),
      .rdata(rdata[g]), .err(err[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = mem_model(mem_addr[g]);
  end
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  task automatic set_port(input int k, input bit p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      dma_req[k] = r; dma_we[k] = w; dma_addr[k] = a; dma_wdata[k] = d;
    end else begin
      cpu_req[k] = r; cpu_we[k] = w; cpu_addr[k] = a; cpu_wdata[k] = d;
    end
  endtask
  task automatic check_outputs_zero(input int k, input string tag);
    check({tag, "_flags"}, 32'({mem_en[k], mem_we[k], cpu_done[k], dma_done[k], err[k]}), 32'd0);
    check({tag, "_mem_addr"}, mem_addr[k], 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata[k], 32'd0);
    check({tag, "_rdata"}, rdata[k], 32'd0);
  endtask
  task automatic run_txn(input vec_t v);
    exp_t e;
    int c = 0;
    int en_n = 0;
    int we_n = 0;
    int other_n = 0;
    bit seen = 0;
    set_port(v.k, v.port, 1'b1, v.we, v.addr, v.wdata);
    if (!v.we && !v.exp_err) rd_model[v.k] = mem_model(v.addr);
    e.rdata = rd_model[v.k];
    e.err   = v.exp_err;
    e.lat   = v.exp_err ? 2 : lat_of(v.k) + 1;
    sb.push_back(e);
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      en_n    += int'(mem_en[v.k]);
      we_n    += int'(mem_we[v.k]);
      other_n += int'(v.port ? cpu_done[v.k] : dma_done[v.k]);
      if (c == 1 && v.scramble) set_port(v.k, v.port, 1'b0, ~v.we, v.addr ^ 32'h1000, ~v.wdata);
      if (v.port ? dma_done[v.k] : cpu_done[v.k]) begin
        seen = 1;
        e = sb.pop_front();
        check("latency", 32'(c), 32'(e.lat));
        check("rdata", rdata[v.k], e.rdata);
        check("err", 32'(err[v.k]), 32'(e.err));
        check("mem_addr_held", mem_addr[v.k], v.addr);
        check("mem_wdata_held", mem_wdata[v.k], v.wdata);
        set_port(v.k, v.port, 1'b0, v.we, v.addr, v.wdata);
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
      set_port(v.k, v.port, 1'b0, v.we, v.addr, v.wdata);
    end
    check("mem_en_cycles", 32'(en_n), v.exp_err ? 32'd0 : 32'd1);
    check("mem_we_cycles", 32'(we_n), (!v.exp_err && v.we) ? 32'd1 : 32'd0);
    check("other_done", 32'(other_n), 32'd0);
    @(negedge clk);
    check("done_single_pulse", 32'({cpu_done[v.k], dma_done[v.k]}), 32'd0);
  endtask
  task automatic add(input int k, input bit p, input bit w, input logic [31:0] a, input logic [31:0] d, input bit s, input bit e);
    vec_t v;
    v.k = k; v.port = p; v.we = w; v.addr = a; v.wdata = d; v.scramble = s; v.exp_err = e;
    vecs.push_back(v);
  endtask
  initial begin
    int ev_cyc[$];
    bit ev_port[$];
    int done_n;
    for (int k = 0; k < 3; k++) begin
      set_port(k, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      set_port(k, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
      rd_model[k] = 32'd0;
    end
    add(0, 1'b0, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0);
    add(0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0);
    add(0, 1'b0, 1'b1, 32'h104, 32'hCAFEF00D, 1'b0, 1'b0);
    add(0, 1'b0, 1'b0, 32'h102, 32'h0, 1'b0, 1'b1);
    add(0, 1'b1, 1'b1, 32'h203, 32'h55AA55AA, 1'b0, 1'b1);
    add(1, 1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b0, 32'h1, 32'h0, 1'b0, 1'b1);
    add(2, 1'b1, 1'b0, 32'h400, 32'h0, 1'b0, 1'b0);
    add(0, 1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 1'b0);
    add(1, 1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 1'b0);
    add(2, 1'b0, 1'b1, 32'h80, 32'h0BADCAFE, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) check_outputs_zero(k, "reset");
    reset = 1'b1;
    @(negedge clk);
    // Both ports held on the LAT=1 instance: CPU first, then strict alternation
    set_port(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_port(0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (cpu_done[0] && dma_done[0]) check("tie_both_done", 32'd1, 32'd0);
      if (cpu_done[0] || dma_done[0]) begin
        ev_cyc.push_back(c);
        ev_port.push_back(dma_done[0]);
      end
      if (c == 11) begin
        set_port(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
      end
    end
    rd_model[0] = mem_model(32'h20);
    check("tie_done_count", 32'(ev_cyc.size()), 32'd4);
    for (int i = 0; i < ev_cyc.size() && i < 4; i++) begin
      check("tie_done_cycle", 32'(ev_cyc[i]), 32'(2 + 3 * i));
      check("tie_done_port", 32'(ev_port[i]), 32'(i % 2));
    end
    foreach (vecs[i]) run_txn(vecs[i]);
    // Reset during WAIT on the LAT=4 instance aborts with no done pulse
    set_port(2, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    repeat (2) @(negedge clk);
    check("pre_reset_rdata_nonzero", 32'(rdata[2] != 32'd0), 32'd1);
    reset = 1'b0;
    #1;
    check_outputs_zero(2, "midop_reset");
    set_port(2, 1'b0, 1'b0, 1'b0, 32'h700, 32'h0);
    for (int k = 0; k < 3; k++) rd_model[k] = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    done_n = 0;
    repeat (6) begin
      @(negedge clk);
      done_n += int'(cpu_done[2]) + int'(dma_done[2]);
    end
    check("no_done_after_abort", 32'(done_n), 32'd0);
    begin
      vec_t v;
      v.k = 2; v.port = 1'b0; v.we = 1'b0; v.addr = 32'h800; v.wdata = 32'h0; v.scramble = 1'b0; v.exp_err = 1'b0;
      run_txn(v);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
